// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
//   Wrapper stage in front of the calculator datapath. Commands arrive on a
//   valid/ready interface and queue in a small FIFO. The FIFO head is issued
//   one per cycle to the calculator. The calculator result is captured one
//   cycle later into a 2-entry in-order result buffer, which is presented on a
//   valid/ready result interface.
//
//   Handshake rule (both interfaces): a transfer happens on a rising clk edge
//   where valid && ready are both high. Valid never depends on ready. While
//   valid is high and ready is low, the payload holds steady.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready  command handshake
//   i_cmd_sel/a/b            op (0 SUM, 1 SUB, 2 MUL, 3 DIV) and operands
//   o_calc_sel/a/b           drive to the calculator (FIFO head, 0 when empty)
//   i_calc_r                 registered calculator result
//   o_res_valid/i_res_ready  result handshake
//   o_res_data, o_res_err    result head; err marks DIV with b==0
//   o_busy                   anything queued, in flight or buffered
module calc_cmd_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int DATA_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_sel,
  input  logic [DATA_W-1:0]     i_cmd_a,
  input  logic [DATA_W-1:0]     i_cmd_b,
  output logic [1:0]            o_calc_sel,
  output logic [DATA_W-1:0]     o_calc_a,
  output logic [DATA_W-1:0]     o_calc_b,
  input  logic [2*DATA_W-1:0]   i_calc_r,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [2*DATA_W-1:0]   o_res_data,
  output logic                  o_res_err,
  output logic                  o_busy
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = 2 * DATA_W;

  // Command FIFO
  logic [1:0]        cmd_sel_mem [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_a_mem   [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_b_mem   [CMD_DEPTH];
  logic [PTR_W-1:0]  cmd_wr_ptr;
  logic [PTR_W-1:0]  cmd_rd_ptr;
  logic [CNT_W-1:0]  cmd_count;
  logic              cmd_empty;
  logic              cmd_full;
  logic              push;

  // Issue / in-flight tracking
  logic              issue;
  logic              inflight;
  logic              tag_divzero;
  logic [1:0]        res_occ;

  // Result buffer
  logic [RES_W-1:0]  res_data_mem [2];
  logic [1:0]        res_err_mem;
  logic              res_wr_ptr;
  logic              res_rd_ptr;
  logic [1:0]        res_count;
  logic              res_pop;
  logic [RES_W-1:0]  capture_data;

  assign cmd_empty   = (cmd_count == '0);
  assign cmd_full    = (cmd_count == CNT_W'(CMD_DEPTH));
  assign o_cmd_ready = !cmd_full;
  assign push        = i_cmd_valid && !cmd_full;

  // Issue looks only at registered occupancy, so the result consumer's ready
  // never reaches the issue decision combinationally. Results already stored
  // plus the one in flight must leave a free buffer slot for the capture.
  assign res_occ = res_count + {1'b0, inflight};
  assign issue   = !cmd_empty && (res_occ < 2'd2);

  assign o_calc_sel = cmd_empty ? 2'd0 : cmd_sel_mem[cmd_rd_ptr];
  assign o_calc_a   = cmd_empty ? '0   : cmd_a_mem[cmd_rd_ptr];
  assign o_calc_b   = cmd_empty ? '0   : cmd_b_mem[cmd_rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_sel_mem[cmd_wr_ptr] <= i_cmd_sel;
      cmd_a_mem[cmd_wr_ptr]   <= i_cmd_a;
      cmd_b_mem[cmd_wr_ptr]   <= i_cmd_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
    end else begin
      if (push)  cmd_wr_ptr <= cmd_wr_ptr + PTR_W'(1);
      if (issue) cmd_rd_ptr <= cmd_rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   cmd_count <= cmd_count + CNT_W'(1);
        2'b01:   cmd_count <= cmd_count - CNT_W'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // inflight marks the cycle in which i_calc_r holds the previously issued
  // command's result. A back-to-back issue keeps it set with a fresh tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      tag_divzero <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) tag_divzero <= (o_calc_sel == 2'd3) && (o_calc_b == '0);
    end
  end

  // Divide-by-zero results ignore whatever the calculator produced.
  assign capture_data = tag_divzero ? '0 : i_calc_r;
  assign res_pop      = (res_count != 2'd0) && i_res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_mem[0] <= '0;
      res_data_mem[1] <= '0;
      res_err_mem     <= '0;
      res_wr_ptr      <= 1'b0;
      res_rd_ptr      <= 1'b0;
      res_count       <= 2'd0;
    end else begin
      if (inflight) begin
        res_data_mem[res_wr_ptr] <= capture_data;
        res_err_mem[res_wr_ptr]  <= tag_divzero;
        res_wr_ptr               <= !res_wr_ptr;
      end
      if (res_pop) res_rd_ptr <= !res_rd_ptr;
      case ({inflight, res_pop})
        2'b10:   res_count <= res_count + 2'd1;
        2'b01:   res_count <= res_count - 2'd1;
        default: res_count <= res_count;
      endcase
    end
  end

  assign o_res_valid = (res_count != 2'd0);
  assign o_res_data  = o_res_valid ? res_data_mem[res_rd_ptr] : '0;
  assign o_res_err   = o_res_valid ? res_err_mem[res_rd_ptr]  : 1'b0;
  assign o_busy      = !cmd_empty || inflight || o_res_valid;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Testbench for calc_cmd_sequencer: directed scenarios followed by randomized
// valid/ready traffic, scored against an in-order expected queue.
`timescale 1ns/1ps
module tb_calc_cmd_sequencer;
  localparam int DW    = 16;
  localparam int RW    = 2 * DW;
  localparam int DEPTH = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_sel = '0;
  logic [DW-1:0] i_cmd_a = '0;
  logic [DW-1:0] i_cmd_b = '0;
  logic [1:0]    o_calc_sel;
  logic [DW-1:0] o_calc_a;
  logic [DW-1:0] o_calc_b;
  logic [RW-1:0] calc_r = '0;
  logic          o_res_valid;
  logic          i_res_ready = 1'b0;
  logic [RW-1:0] o_res_data;
  logic          o_res_err;
  logic          o_busy;

  calc_cmd_sequencer #(.CMD_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_sel(i_cmd_sel), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b),
    .o_calc_sel(o_calc_sel), .o_calc_a(o_calc_a), .o_calc_b(o_calc_b),
    .i_calc_r(calc_r),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_res_err(o_res_err), .o_busy(o_busy)
  );

  // Stand-in for the calculator: registers its result every edge. A divide
  // by zero returns junk that the sequencer must discard.
  always @(posedge clk) begin
    case (o_calc_sel)
      2'd0:    calc_r <= {16'h0, o_calc_a} + {16'h0, o_calc_b};
      2'd1:    calc_r <= {16'h0, o_calc_a} - {16'h0, o_calc_b};
      2'd2:    calc_r <= {16'h0, o_calc_a} * {16'h0, o_calc_b};
      default: calc_r <= (o_calc_b == '0) ? 32'hDEAD_BEEF
                                          : {16'h0, o_calc_a / o_calc_b};
    endcase
  end

  // Reference model: {err, data} for one command, from plain integer math.
  function automatic logic [RW:0] ref_result(input logic [1:0] sel,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    longint ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    r  = 0;
    case (sel)
      2'd0: r = ua + ub;
      2'd1: r = ua - ub;
      2'd2: r = ua * ub;
      default: begin
        if (ub == 0) return {1'b1, {RW{1'b0}}};
        r = ua / ub;
      end
    endcase
    return {1'b0, r[RW-1:0]};
  endfunction

  // Scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_res   = 0;
  int n_drop  = 0;
  logic [RW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising
  // edge will act on.
  initial begin
    logic [RW:0] cur;
    logic [RW:0] prev_out;
    logic        prev_hold;
    prev_hold = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (i_cmd_valid && o_cmd_ready) begin
          exp_q.push_back(ref_result(i_cmd_sel, i_cmd_a, i_cmd_b));
          n_acc++;
        end
        cur = {o_res_err, o_res_data};
        if (o_res_valid) begin
          if (prev_hold) check("res_stable", 64'(cur), 64'(prev_out));
          if (exp_q.size() == 0) begin
            check("res_unexpected", 64'(exp_q.size()), 64'd1);
          end else begin
            check("res_data", 64'(cur), 64'(exp_q[0]));
            if (i_res_ready) begin
              void'(exp_q.pop_front());
              n_res++;
            end
          end
        end
        prev_hold = o_res_valid && !i_res_ready;
        prev_out  = cur;
      end
    end
  end

  // Driver tasks (entered and left just after a rising edge)
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic acc;
    i_cmd_valid = 1'b1;
    i_cmd_sel   = sel;
    i_cmd_a     = a;
    i_cmd_b     = b;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = o_cmd_ready;
      @(posedge clk);
      #1;
    end
    i_cmd_valid = 1'b0;
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  // Counts falling edges after the current point until o_res_valid is seen.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_res_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("wait_valid_timeout", 64'(o_res_valid), 64'd1);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) idle(1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(o_res_valid), 64'd0);
    check({tag, "_res_data"},  64'(o_res_data),  64'd0);
    check({tag, "_res_err"},   64'(o_res_err),   64'd0);
    check({tag, "_busy"},      64'(o_busy),      64'd0);
    check({tag, "_calc"},      64'({o_calc_sel, o_calc_a, o_calc_b}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n0;
    bit drv_done;

    // Reset
    #2 rst = 1'b1;
    #1 check_idle_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    check_idle_outputs("post_rst");

    // SUM 3+5, two cycles from accept to valid
    i_res_ready = 1'b1;
    send(2'd0, 16'h0003, 16'h0005);
    wait_valid(lat);
    check("sum_latency", 64'(lat), 64'd2);
    check("sum_data", 64'(o_res_data), 64'h8);
    check("sum_err", 64'(o_res_err), 64'd0);
    idle(3);

    // SUB then MUL back-to-back, results on consecutive cycles
    send(2'd1, 16'd3, 16'd5);
    send(2'd2, 16'hFFFF, 16'hFFFF);
    wait_valid(lat);
    check("sub_latency", 64'(lat), 64'd1);
    check("sub_data", 64'(o_res_data), 64'hFFFF_FFFE);
    @(negedge clk);
    check("mul_consecutive", 64'(o_res_valid), 64'd1);
    check("mul_data", 64'(o_res_data), 64'hFFFE_0001);
    idle(3);

    // DIV 100/7, then DIV 100/0
    send(2'd3, 16'd100, 16'd7);
    send(2'd3, 16'd100, 16'd0);
    wait_valid(lat);
    check("div_data", 64'({o_res_err, o_res_data}), 64'h0_0000_000E);
    @(negedge clk);
    check("div0_valid", 64'(o_res_valid), 64'd1);
    check("div0_data", 64'({o_res_err, o_res_data}), 64'h1_0000_0000);
    idle(3);

    // Back-pressure: 2 results buffered + DEPTH queued, then release
    i_res_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(2'd0, DW'(i), 16'd100);
    idle(4);
    check("full_cmd_ready", 64'(o_cmd_ready), 64'd0);
    check("full_res_valid", 64'(o_res_valid), 64'd1);
    check("full_res_head", 64'(o_res_data), 64'd100);
    check("full_calc_head", 64'(o_calc_a), 64'd2);
    check("full_busy", 64'(o_busy), 64'd1);
    n0 = n_res;
    i_res_ready = 1'b1;
    drain(50);
    check("full_all_results", 64'(n_res - n0), 64'd6);
    idle(2);

    // Asynchronous reset with FIFO=3, one in flight, buffer empty
    i_res_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(2'd0, DW'(10 + i), 16'd1);
    idle(3);
    i_res_ready = 1'b1;
    idle(2);
    #2;
    check("pre_rst_busy", 64'(o_busy), 64'd1);
    check("pre_rst_head", 64'(o_calc_a), 64'd13);
    check("pre_rst_res_valid", 64'(o_res_valid), 64'd0);
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    n_drop += exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale", 64'(o_res_valid), 64'd0);
    end
    idle(1);
    send(2'd3, 16'd50, 16'd5);
    wait_valid(lat);
    check("post_rst_latency", 64'(lat), 64'd2);
    check("post_rst_data", 64'({o_res_err, o_res_data}), 64'h0_0000_000A);
    idle(3);

    // Randomized traffic
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [1:0]    sel;
          logic [DW-1:0] a;
          logic [DW-1:0] b;
          sel = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0:       a = '0;
            1:       a = '1;
            default: a = DW'($urandom);
          endcase
          case ($urandom_range(0, 4))
            0:       b = '0;
            1:       b = '1;
            default: b = DW'($urandom);
          endcase
          repeat ($urandom_range(0, 2)) idle(1);
          send(sel, a, b);
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          i_res_ready = 1'($urandom_range(0, 1));
          idle(1);
        end
      end
    join
    i_res_ready = 1'b1;
    drain(100);
    check("acc_vs_res", 64'(n_res + n_drop), 64'(n_acc));
    idle(2);
    check("end_busy", 64'(o_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
